// File: rtl/line_buffer_nrows.sv
// N-row line buffer: N-1 circular line memories sharing one column pointer, emitting one
// vertical column of P_NUM_ROWS pixels per accepted pixel once P_NUM_ROWS-1 lines are stored.
module line_buffer_nrows #(
   parameter int P_DATA_WIDTH = 8,
   parameter int P_LINE_WIDTH = 640,
   parameter int P_NUM_ROWS   = 3
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic                                 i_valid,
   input  logic                                 i_sof,
   input  logic [P_DATA_WIDTH-1:0]              i_data,
   output logic                                 o_valid,
   output logic [P_DATA_WIDTH*P_NUM_ROWS-1:0]   o_col,
   output logic [$clog2(P_LINE_WIDTH)-1:0]      o_x,
   output logic                                 o_eol,
   output logic                                 o_primed
);

   localparam int DW = P_DATA_WIDTH;
   localparam int CW = P_DATA_WIDTH * P_NUM_ROWS;
   localparam int NM = P_NUM_ROWS - 1;
   localparam int XW = $clog2(P_LINE_WIDTH);
   localparam int RW = (P_NUM_ROWS > 2) ? $clog2(P_NUM_ROWS) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(P_LINE_WIDTH - 1);
   localparam logic [RW-1:0] R_FULL = RW'(P_NUM_ROWS - 1);

   logic [DW-1:0] line_mem [NM][P_LINE_WIDTH];
   logic [DW-1:0] rd_col [NM];
   logic [XW-1:0] addr;

   logic [XW-1:0] ptr_q, ptr_d;
   logic [RW-1:0] rows_filled_q, rows_filled_d;
   logic          valid_q, valid_d;
   logic [CW-1:0] col_q, col_d;
   logic [XW-1:0] x_q, x_d;
   logic          eol_q, eol_d;

   // A frame-start pixel always lands at column 0, whatever the pointer says.
   always_comb begin
      addr = i_sof ? '0 : ptr_q;
      for (int j = 0; j < NM; j++) begin
         rd_col[j] = line_mem[j][addr];
      end
   end

   always_comb begin
      ptr_d         = ptr_q;
      rows_filled_d = rows_filled_q;
      valid_d       = 1'b0;
      col_d         = col_q;
      x_d           = x_q;
      eol_d         = eol_q;
      if (i_valid) begin
         if (i_sof) begin
            ptr_d         = XW'(1);
            rows_filled_d = '0;
         end else begin
            if (ptr_q == X_LAST) begin
               ptr_d = '0;
               if (rows_filled_q != R_FULL) begin
                  rows_filled_d = rows_filled_q + RW'(1);
               end
            end else begin
               ptr_d = ptr_q + XW'(1);
            end
            if (rows_filled_q == R_FULL) begin
               valid_d          = 1'b1;
               col_d[0 +: DW]   = i_data;
               for (int k = 1; k < P_NUM_ROWS; k++) begin
                  col_d[k*DW +: DW] = rd_col[k-1];
               end
               x_d   = ptr_q;
               eol_d = (ptr_q == X_LAST);
            end
         end
      end
   end

   // Line memories are never cleared; the unprimed state keeps stale contents off o_col.
   always_ff @(posedge i_clk) begin
      if (i_valid) begin
         line_mem[0][addr] <= i_data;
         for (int j = 1; j < NM; j++) begin
            line_mem[j][addr] <= rd_col[j-1];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr_q         <= '0;
         rows_filled_q <= '0;
         valid_q       <= 1'b0;
         col_q         <= '0;
         x_q           <= '0;
         eol_q         <= 1'b0;
      end else begin
         ptr_q         <= ptr_d;
         rows_filled_q <= rows_filled_d;
         valid_q       <= valid_d;
         col_q         <= col_d;
         x_q           <= x_d;
         eol_q         <= eol_d;
      end
   end

   assign o_valid  = valid_q;
   assign o_col    = col_q;
   assign o_x      = x_q;
   assign o_eol    = eol_q;
   assign o_primed = (rows_filled_q == R_FULL);

endmodule

// File: tb/tb_line_buffer_nrows.sv
// Scoreboard bench for line_buffer_nrows: a line-history model predicts each column,
// a negedge monitor pops and compares whenever the DUT asserts o_valid.
module tb_line_buffer_nrows;

   localparam int DW  = 8;
   localparam int W   = 4;
   localparam int N   = 3;
   localparam int CW  = DW * N;
   localparam int XW  = $clog2(W);
   localparam int WB  = 2;
   localparam int NB  = 5;
   localparam int CWB = DW * NB;
   localparam int XWB = $clog2(WB);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, valid, sof;
   logic [DW-1:0] data;
   logic          o_valid, o_eol, o_primed;
   logic [CW-1:0] o_col;
   logic [XW-1:0] o_x;

   logic           b_rst, b_valid, b_sof;
   logic [DW-1:0]  b_data;
   logic           b_o_valid, b_o_eol, b_o_primed;
   logic [CWB-1:0] b_o_col;
   logic [XWB-1:0] b_o_x;

   line_buffer_nrows #(.P_DATA_WIDTH(DW), .P_LINE_WIDTH(W), .P_NUM_ROWS(N)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sof(sof), .i_data(data),
      .o_valid(o_valid), .o_col(o_col), .o_x(o_x), .o_eol(o_eol), .o_primed(o_primed));

   line_buffer_nrows #(.P_DATA_WIDTH(DW), .P_LINE_WIDTH(WB), .P_NUM_ROWS(NB)) dut_b (
      .i_clk(clk), .i_rst(b_rst), .i_valid(b_valid), .i_sof(b_sof), .i_data(b_data),
      .o_valid(b_o_valid), .o_col(b_o_col), .o_x(b_o_x), .o_eol(b_o_eol), .o_primed(b_o_primed));

   typedef struct {
      logic [CW-1:0] col;
      int            x;
      logic          eol;
   } exp_t;

   typedef logic [DW-1:0] line_t [W];

   exp_t        exp_q[$];
   logic [63:0] exp_b_q[$];
   line_t       done_q[$];
   line_t       cur_line;
   int          cur_x = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        mon_e;
   logic [63:0] mon_b;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: keep the last N-1 completed lines of the frame; a column is the new pixel
   // stacked on the same x of those lines, newest first.
   task automatic model_pixel(input logic sof_in, input logic [DW-1:0] d);
      exp_t e;
      if (sof_in) begin
         done_q.delete();
         cur_x = 0;
      end else if (done_q.size() == N-1) begin
         e.col = CW'(d);
         for (int k = 1; k < N; k++) begin
            e.col[k*DW +: DW] = done_q[done_q.size()-k][cur_x];
         end
         e.x   = cur_x;
         e.eol = (cur_x == W-1);
         exp_q.push_back(e);
      end
      cur_line[cur_x] = d;
      cur_x++;
      if (cur_x == W) begin
         done_q.push_back(cur_line);
         if (done_q.size() > N-1) done_q.delete(0);
         cur_x = 0;
      end
   endtask

   task automatic apply_stimulus(input logic sof_in, input logic [DW-1:0] d, input bit gaps);
      if (gaps && $urandom_range(0, 2) == 0) begin
         valid = 1'b0;
         sof   = $urandom_range(0, 1);
         repeat ($urandom_range(1, 2)) @(posedge clk);
         #1;
      end
      model_pixel(sof_in, d);
      valid = 1'b1;
      sof   = sof_in;
      data  = d;
      @(posedge clk);
      #1;
      valid = 1'b0;
      sof   = 1'b0;
      data  = DW'($urandom);
   endtask

   task automatic apply_reset();
      rst   = 1'b1;
      valid = 1'b0;
      sof   = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      done_q.delete();
      cur_x = 0;
   endtask

   task automatic stream_rows(input int r0, input int r1, input bit sof_first, input bit gaps);
      for (int r = r0; r <= r1; r++) begin
         for (int c = 0; c < W; c++) begin
            apply_stimulus(sof_first && r == r0 && c == 0, DW'(r*16 + c), gaps);
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_output({tag, "_valid"},  64'(o_valid),  64'd0);
      check_output({tag, "_col"},    64'(o_col),    64'd0);
      check_output({tag, "_x"},      64'(o_x),      64'd0);
      check_output({tag, "_eol"},    64'(o_eol),    64'd0);
      check_output({tag, "_primed"}, 64'(o_primed), 64'd0);
   endtask

   always @(negedge clk) begin
      if (o_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_column: got col %0h x %0d, required none", o_col, o_x);
         end else begin
            mon_e = exp_q.pop_front();
            check_output("sb_col", 64'(o_col), 64'(mon_e.col));
            check_output("sb_x",   64'(o_x),   64'(mon_e.x));
            check_output("sb_eol", 64'(o_eol), 64'(mon_e.eol));
         end
      end
      if (b_o_valid) begin
         if (exp_b_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_column_b: got col %0h, required none", b_o_col);
         end else begin
            mon_b = exp_b_q.pop_front();
            check_output("sb_b_col", 64'(b_o_col), mon_b);
         end
      end
   end

   initial begin
      logic [63:0] bexp;
      rst = 1'b1; valid = 1'b0; sof = 1'b0; data = '0;
      b_rst = 1'b1; b_valid = 1'b0; b_sof = 1'b0; b_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      b_rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset");

      // Priming: rows 0 and 1 produce nothing; primed appears after pixel (1,3)
      stream_rows(0, 0, 1'b1, 1'b0);
      for (int c = 0; c < W-1; c++) apply_stimulus(1'b0, DW'(16 + c), 1'b0);
      @(negedge clk);
      check_output("prime_before", 64'(o_primed), 64'd0);
      apply_stimulus(1'b0, 8'h13, 1'b0);
      @(negedge clk);
      check_output("prime_after", 64'(o_primed), 64'd1);
      check_output("prime_novalid", 64'(o_valid), 64'd0);

      // Columns with random bubbles in rows 2-3
      apply_stimulus(1'b0, 8'h20, 1'b0);
      @(negedge clk);
      check_output("col20_valid", 64'(o_valid), 64'd1);
      check_output("col20", 64'(o_col), 64'h001020);
      check_output("col20_x", 64'(o_x), 64'd0);
      check_output("col20_eol", 64'(o_eol), 64'd0);
      apply_stimulus(1'b0, 8'h21, 1'b1);
      apply_stimulus(1'b0, 8'h22, 1'b1);
      apply_stimulus(1'b0, 8'h23, 1'b1);
      @(negedge clk);
      check_output("col23", 64'(o_col), 64'h031323);
      check_output("col23_eol", 64'(o_eol), 64'd1);
      apply_stimulus(1'b0, 8'h30, 1'b1);
      apply_stimulus(1'b0, 8'h31, 1'b1);
      @(negedge clk);
      check_output("col31", 64'(o_col), 64'h112131);
      apply_stimulus(1'b0, 8'h32, 1'b1);
      apply_stimulus(1'b0, 8'h33, 1'b1);

      // Mid-line resync on pixel (3,2)
      stream_rows(0, 2, 1'b1, 1'b1);
      apply_stimulus(1'b0, 8'h30, 1'b0);
      apply_stimulus(1'b0, 8'h31, 1'b0);
      apply_stimulus(1'b1, 8'h32, 1'b0);
      @(negedge clk);
      check_output("resync_valid", 64'(o_valid), 64'd0);
      check_output("resync_primed", 64'(o_primed), 64'd0);
      for (int i = 0; i < 2*W-1; i++) apply_stimulus(1'b0, DW'($urandom), 1'b1);
      @(negedge clk);
      check_output("resync_reprimed", 64'(o_primed), 64'd1);
      for (int i = 0; i < W; i++) apply_stimulus(1'b0, DW'($urandom), 1'b1);

      // Reset during row 2, then restart without a frame start
      stream_rows(0, 1, 1'b1, 1'b0);
      apply_stimulus(1'b0, 8'h20, 1'b0);
      apply_stimulus(1'b0, 8'h21, 1'b0);
      apply_reset();
      @(negedge clk);
      check_idle_outputs("midreset");
      stream_rows(0, 1, 1'b0, 1'b0);
      @(negedge clk);
      check_output("restart_novalid", 64'(o_valid), 64'd0);
      apply_stimulus(1'b0, 8'h20, 1'b0);
      @(negedge clk);
      check_output("restart_valid", 64'(o_valid), 64'd1);
      check_output("restart_col", 64'(o_col), 64'h001020);

      // Random data, random frame starts, random bubbles
      for (int i = 0; i < 300; i++) begin
         apply_stimulus($urandom_range(0, 40) == 0, DW'($urandom), 1'b1);
      end

      // Five-row, two-pixel-wide instance
      for (int r = 0; r < NB; r++) begin
         for (int c = 0; c < WB; c++) begin
            if (r == NB-1) begin
               bexp = '0;
               for (int k = 0; k < NB; k++) bexp[k*DW +: DW] = DW'((NB-1-k)*16 + c);
               exp_b_q.push_back(bexp);
            end
            b_valid = 1'b1;
            b_sof   = (r == 0 && c == 0);
            b_data  = DW'(r*16 + c);
            @(posedge clk);
            #1;
            b_valid = 1'b0;
            b_sof   = 1'b0;
            if (r == NB-2 && c == WB-1) begin
               @(negedge clk);
               check_output("b_primed", 64'(b_o_primed), 64'd1);
            end
            if (r == NB-1 && c == 0) begin
               @(negedge clk);
               check_output("b_col40", 64'(b_o_col), 64'h0010203040);
            end
         end
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("sb_drain", 64'(exp_q.size()), 64'd0);
      check_output("sb_b_drain", 64'(exp_b_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
